data_mem_access_ctrl: RTL and testbench

//  Initiator-side load/store controller for the 32-bit byte-enabled data memory
//  (ena / wea[3:0] / addra / dina / douta port).

---
 rtl/data_mem_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_access_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_ctrl.sv
// Load/store controller for a 32-bit byte-enabled data memory.
// It takes one request at a time and turns byte, half and word accesses into a
// single word-wide memory cycle with lane enables. It waits out the read latency,
// then returns the extracted and extended load data on a response channel.
//
// Handshake (both channels): a transfer happens on a rising edge where valid and
// ready are both 1. The request side is sampled only while req_ready=1 (IDLE).
// rsp_valid, rsp_rdata and rsp_err are held stable until the edge where
// rsp_ready=1 is seen. No new request is accepted before that edge, so at most
// one access is outstanding at any time.
module data_mem_access_ctrl #(
  parameter int READ_LATENCY = 1  // legal range 1..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_ena,
  output logic [3:0]  mem_wea,
  output logic [31:0] mem_addra,
  output logic [31:0] mem_dina,
  input  logic [31:0] mem_douta
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Fields latched at acceptance and used by the later states.
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [3:0]  mask_q;
  logic [2:0]  wait_cnt;

  logic        accept;
  logic        wait_done;
  logic        req_err;
  logic [3:0]  req_mask;
  logic [31:0] req_dina;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign accept    = (state == IDLE) && req_valid;
  assign wait_done = (wait_cnt == 3'(READ_LATENCY - 1));

  // Decode the incoming request: alignment check, lane mask, lane-replicated data.
  always_comb begin
    req_err  = 1'b0;
    req_mask = 4'b0000;
    req_dina = req_wdata;
    case (req_size)
      2'b00: begin
        req_mask = 4'b0001 << req_addr[1:0];
        req_dina = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        req_dina = {2{req_wdata[15:0]}};
        req_err  = req_addr[0];
      end
      2'b10: begin
        req_mask = 4'b1111;
        req_err  = (req_addr[1:0] != 2'b00);
      end
      default: begin
        req_err  = 1'b1;
      end
    endcase
  end

  // Select the addressed byte/half from the returned word and extend it.
  always_comb begin
    load_byte = mem_douta[7:0];
    case (off_q)
      2'd1:    load_byte = mem_douta[15:8];
      2'd2:    load_byte = mem_douta[23:16];
      2'd3:    load_byte = mem_douta[31:24];
      default: load_byte = mem_douta[7:0];
    endcase
    load_half = off_q[1] ? mem_douta[31:16] : mem_douta[15:0];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{signed_q & load_half[15]}}, load_half};
      default: load_data = mem_douta;
    endcase
  end

  // Next-state logic: errors skip the memory, stores skip the read wait.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (wait_done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register; they follow rst asynchronously.
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP);
    mem_ena   = (state == ACCESS);
    mem_wea   = ((state == ACCESS) && we_q) ? mask_q : 4'b0000;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch, wait counter and response data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      mask_q    <= 4'b0000;
      wait_cnt  <= 3'd0;
      mem_addra <= 32'd0;
      mem_dina  <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= req_err;
      rsp_rdata <= 32'd0;
      wait_cnt  <= 3'd0;
      if (!req_err) begin
        we_q      <= req_we;
        signed_q  <= req_signed;
        size_q    <= req_size;
        off_q     <= req_addr[1:0];
        mask_q    <= req_mask;
        mem_addra <= {2'b00, req_addr[31:2]};
        mem_dina  <= req_dina;
      end
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 3'd1;
      if (wait_done) begin
        rsp_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Bench for data_mem_access_ctrl. Two instances share clock and reset:
// unit 0 with READ_LATENCY=1 and unit 1 with READ_LATENCY=3. Each has its own
// word memory with the configured read latency. A byte-addressed shadow
// memory drives a per-cycle reference model; directed requests also carry
// hand-computed expected values.
//
// Edge numbering: E0 is the clock edge right after which the driver raises
// req_valid; the request is taken on E1. A response first seen after edge En
// is reported as latency n (error 1, store 2, load 2+READ_LATENCY).
module tb_data_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]        req_valid, req_ready, req_we, req_signed;
  logic [1:0][1:0]   req_size;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0]        rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0]  rsp_rdata;
  logic [1:0]        mem_ena;
  logic [1:0][3:0]   mem_wea;
  logic [1:0][31:0]  mem_addra, mem_dina;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ena_cnt;
    logic [3:0]  wea;
    logic [31:0] addra;
    logic [31:0] dina;
  } res_t;

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : unit
    localparam int LATG = (g == 0) ? 1 : 3;
    logic [31:0] mem [16];
    logic [31:0] pipe [4];
    logic [31:0] douta;

    data_mem_access_ctrl #(.READ_LATENCY(LATG)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_size  (req_size[g]),
      .req_signed(req_signed[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .mem_ena   (mem_ena[g]),
      .mem_wea   (mem_wea[g]),
      .mem_addra (mem_addra[g]),
      .mem_dina  (mem_dina[g]),
      .mem_douta (douta)
    );

    // Memory: read data appears LATG edges after the sampling edge; garbage otherwise.
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        for (int i = 0; i < 4; i++) pipe[i] <= 32'hDEADBEEF;
      end else begin
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        pipe[0] <= (mem_ena[g] && mem_wea[g] == 4'b0000) ? mem[mem_addra[g][3:0]] : 32'hDEADBEEF;
        if (mem_ena[g]) begin
          for (int i = 0; i < 4; i++)
            if (mem_wea[g][i]) mem[mem_addra[g][3:0]][8*i +: 8] = mem_dina[g][8*i +: 8];
        end
      end
    end
    assign douta = pipe[LATG-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy [2];
  int          m_age [2];
  int          m_rsp_at [2];
  logic        m_err [2];
  logic        m_we [2];
  logic [3:0]  m_mask [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_dina [2];
  logic [31:0] m_rdata [2];
  logic [7:0]  shadow [2][64];

  task automatic model_accept(input int u);
    int nb;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] v;
    a = req_addr[u];
    w = req_wdata[u];
    case (req_size[u])
      2'b00:   nb = 1;
      2'b01:   nb = 2;
      2'b10:   nb = 4;
      default: nb = 0;
    endcase
    m_busy[u]  = 1'b1;
    m_age[u]   = 0;
    m_we[u]    = req_we[u];
    m_err[u]   = (nb == 0) ? 1'b1 : ((a % nb) != 0);
    m_mask[u]  = 4'(((1 << nb) - 1) << a[1:0]);
    m_addr[u]  = a >> 2;
    m_dina[u]  = (nb == 1) ? {4{w[7:0]}} : (nb == 2) ? {2{w[15:0]}} : w;
    m_rsp_at[u] = m_err[u] ? 0 : (m_we[u] ? 1 : 1 + lat_of(u));
    m_rdata[u] = 32'd0;
    if (!m_err[u]) begin
      if (m_we[u]) begin
        for (int i = 0; i < nb; i++) shadow[u][(int'(a[5:0]) + i) % 64] = w[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | ({24'd0, shadow[u][(int'(a[5:0]) + i) % 64]} << (8*i));
        if (nb < 4 && req_signed[u] && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
        m_rdata[u] = v;
      end
    end
  endtask

  task automatic step(input int u);
    logic       e_ena;
    logic       e_rv;
    logic [3:0] e_wea;
    string      p;
    p = $sformatf("u%0d@%0d", u, cyc);
    if (rst) begin
      chk({p, " rst req_ready"}, 32'(req_ready[u]), 32'd0);
      chk({p, " rst mem_ena"},   32'(mem_ena[u]),   32'd0);
      chk({p, " rst mem_wea"},   32'(mem_wea[u]),   32'd0);
      chk({p, " rst rsp_valid"}, 32'(rsp_valid[u]), 32'd0);
      chk({p, " rst rsp_err"},   32'(rsp_err[u]),   32'd0);
      chk({p, " rst rsp_rdata"}, rsp_rdata[u],      32'd0);
      chk({p, " rst mem_addra"}, mem_addra[u],      32'd0);
      m_busy[u] = 1'b0;
      for (int i = 0; i < 64; i++) shadow[u][i] = 8'd0;
      return;
    end
    e_ena = m_busy[u] && !m_err[u] && (m_age[u] == 0);
    e_wea = (e_ena && m_we[u]) ? m_mask[u] : 4'b0000;
    e_rv  = m_busy[u] && (m_age[u] >= m_rsp_at[u]);
    chk({p, " req_ready"}, 32'(req_ready[u]), 32'(!m_busy[u]));
    chk({p, " mem_ena"},   32'(mem_ena[u]),   32'(e_ena));
    chk({p, " mem_wea"},   32'(mem_wea[u]),   32'(e_wea));
    chk({p, " rsp_valid"}, 32'(rsp_valid[u]), 32'(e_rv));
    if (e_ena) begin
      chk({p, " mem_addra"}, mem_addra[u], m_addr[u]);
      if (m_we[u]) chk({p, " mem_dina"}, mem_dina[u], m_dina[u]);
    end
    if (e_rv) begin
      chk({p, " rsp_rdata"}, rsp_rdata[u], m_rdata[u]);
      chk({p, " rsp_err"},   32'(rsp_err[u]), 32'(m_err[u]));
    end
    // Advance to the coming edge using the inputs that will be sampled there.
    if (m_busy[u]) begin
      if (e_rv && rsp_ready[u]) m_busy[u] = 1'b0;
      else m_age[u]++;
    end else if (req_valid[u]) begin
      model_accept(u);
    end
  endtask

  // Compare process: checks both units on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) step(u);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_req(input int u, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output res_t r);
    int n;
    r.rdata = 32'd0; r.err = 1'b0; r.lat = -1; r.ena_cnt = 0;
    r.wea = 4'd0; r.addra = 32'd0; r.dina = 32'd0;
    @(posedge clk); #1;
    req_we[u] = we; req_size[u] = size; req_signed[u] = sgn;
    req_addr[u] = addr; req_wdata[u] = wdata;
    rsp_ready[u] = (hold == 0);
    req_valid[u] = 1'b1;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    n = 1;
    @(negedge clk);
    while (n < 20) begin
      if (mem_ena[u]) begin
        r.ena_cnt++;
        r.wea = mem_wea[u]; r.addra = mem_addra[u]; r.dina = mem_dina[u];
      end
      if (rsp_valid[u]) break;
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[u]) begin
      chk($sformatf("u%0d response timeout", u), 32'(rsp_valid[u]), 32'd1);
      rsp_ready[u] = 1'b1;
      return;
    end
    r.lat = n; r.rdata = rsp_rdata[u]; r.err = rsp_err[u];
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #2;
      chk($sformatf("u%0d hold%0d req_ready", u, k), 32'(req_ready[u]), 32'd0);
      chk($sformatf("u%0d hold%0d rsp_valid", u, k), 32'(rsp_valid[u]), 32'd1);
    end
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("u%0d idle after rsp req_ready", u), 32'(req_ready[u]), 32'd1);
    chk($sformatf("u%0d idle after rsp rsp_valid", u), 32'(rsp_valid[u]), 32'd0);
  endtask

  task automatic exp_rsp(input string t, input res_t r, input logic err,
                         input logic [31:0] rdata, input int lat);
    chk({t, " rsp_err"},   32'(r.err), 32'(err));
    chk({t, " rsp_rdata"}, r.rdata,    rdata);
    chk({t, " latency"},   32'(r.lat), 32'(lat));
  endtask

  task automatic exp_mem(input string t, input res_t r, input int ena_cnt, input logic [3:0] wea,
                         input logic [31:0] addra);
    chk({t, " ena cycles"}, 32'(r.ena_cnt), 32'(ena_cnt));
    chk({t, " mem_wea"},    32'(r.wea),     32'(wea));
    chk({t, " mem_addra"},  r.addra,        addra);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    res_t r;
    rst = 1'b0;
    req_valid = '0; req_we = '0; req_signed = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 2'b11;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready[0]), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("req_ready after reset", 32'(req_ready[0]), 32'd1);

    // Store word 54 at 0, then load it back.
    do_req(0, 1'b1, 2'b10, 1'b0, 32'd0, 32'd54, 0, r);
    exp_rsp("t1 store word", r, 1'b0, 32'd0, 2);
    exp_mem("t1 store word", r, 1, 4'b1111, 32'd0);
    chk("t1 mem_dina", r.dina, 32'd54);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 0, r);
    exp_rsp("t2 load word", r, 1'b0, 32'd54, 3);
    exp_mem("t2 load word", r, 1, 4'b0000, 32'd0);

    // Byte store to address 5, signed and unsigned loads.
    do_req(0, 1'b1, 2'b00, 1'b0, 32'd5, 32'h0000_0080, 0, r);
    exp_rsp("t3 store byte", r, 1'b0, 32'd0, 2);
    exp_mem("t3 store byte", r, 1, 4'b0010, 32'd1);
    chk("t3 mem_dina", r.dina, 32'h8080_8080);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'd5, 32'd0, 0, r);
    exp_rsp("t3 load byte signed", r, 1'b0, 32'hFFFF_FF80, 3);
    do_req(0, 1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 0, r);
    exp_rsp("t3 load byte unsigned", r, 1'b0, 32'h0000_0080, 3);

    // Half store to the upper lanes and assorted loads around it.
    do_req(0, 1'b1, 2'b01, 1'b0, 32'd10, 32'h1234_BEEF, 0, r);
    exp_mem("half store", r, 1, 4'b1100, 32'd2);
    chk("half store mem_dina", r.dina, 32'hBEEF_BEEF);
    do_req(0, 1'b0, 2'b01, 1'b1, 32'd10, 32'd0, 0, r);
    exp_rsp("load half signed", r, 1'b0, 32'hFFFF_BEEF, 3);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'd10, 32'd0, 0, r);
    exp_rsp("load half unsigned", r, 1'b0, 32'h0000_BEEF, 3);
    do_req(0, 1'b0, 2'b10, 1'b1, 32'd8, 32'd0, 0, r);
    exp_rsp("load word 8", r, 1'b0, 32'hBEEF_0000, 3);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'd11, 32'd0, 0, r);
    exp_rsp("load byte 11 signed", r, 1'b0, 32'hFFFF_FFBE, 3);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'd12, 32'h1122_3344, 0, r);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'd14, 32'd0, 0, r);
    exp_rsp("load half 14", r, 1'b0, 32'h0000_1122, 3);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'd13, 32'd0, 0, r);
    exp_rsp("load byte 13 signed", r, 1'b0, 32'h0000_0033, 3);

    // Error requests: no memory cycle, response after E1.
    do_req(0, 1'b0, 2'b01, 1'b0, 32'd3, 32'd0, 0, r);
    exp_rsp("t4 half misaligned", r, 1'b1, 32'd0, 1);
    chk("t4 half misaligned ena cycles", 32'(r.ena_cnt), 32'd0);
    do_req(0, 1'b1, 2'b11, 1'b0, 32'd0, 32'hFFFF_FFFF, 0, r);
    exp_rsp("t4 size11 store", r, 1'b1, 32'd0, 1);
    chk("t4 size11 ena cycles", 32'(r.ena_cnt), 32'd0);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'd2, 32'd0, 0, r);
    exp_rsp("t4 word misaligned", r, 1'b1, 32'd0, 1);
    do_req(0, 1'b1, 2'b01, 1'b0, 32'd1, 32'hAAAA_AAAA, 0, r);
    exp_rsp("t4 half store misaligned", r, 1'b1, 32'd0, 1);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 0, r);
    exp_rsp("t4 word 0 untouched", r, 1'b0, 32'd54, 3);

    // Back-pressure on a load response.
    do_req(0, 1'b0, 2'b10, 1'b0, 32'd12, 32'd0, 5, r);
    exp_rsp("t5 held load", r, 1'b0, 32'h1122_3344, 3);

    // Longer read latency on unit 1.
    do_req(1, 1'b1, 2'b10, 1'b0, 32'd4, 32'hCAFE_F00D, 0, r);
    exp_rsp("u1 store word", r, 1'b0, 32'd0, 2);
    do_req(1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 0, r);
    exp_rsp("u1 load word", r, 1'b0, 32'hCAFE_F00D, 5);
    do_req(1, 1'b0, 2'b00, 1'b1, 32'd7, 32'd0, 0, r);
    exp_rsp("u1 load byte signed", r, 1'b0, 32'hFFFF_FFCA, 5);

    // Reset in the middle of a load wait.
    @(posedge clk); #1;
    req_we[1] = 1'b0; req_size[1] = 2'b10; req_signed[1] = 1'b0;
    req_addr[1] = 32'd4; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("t6 in wait mem_ena", 32'(mem_ena[1]), 32'd0);
    chk("t6 in wait mem_addra", mem_addra[1], 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst mem_ena", 32'(mem_ena[1]), 32'd0);
    chk("t6 rst mem_wea", 32'(mem_wea[1]), 32'd0);
    chk("t6 rst mem_addra", mem_addra[1], 32'd0);
    chk("t6 rst rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("t6 rst req_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("t6 req_ready after rst", 32'(req_ready[1]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t6 no response %0d", k), 32'(rsp_valid[1]), 32'd0);
    end
    do_req(1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 0, r);
    exp_rsp("t6 load after rst", r, 1'b0, 32'd0, 5);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
